// File: rtl/ctr163_chain_ctrl_if.sv
// ---------------------------------------------------------------------------
// ctr163_chain_ctrl_if
//   Bundles the control-side and chain-side signals of the 74x163 chain
//   sequencer.
//   Control side: start, stop, pause, mode and count come in; busy, tick and
//                 done go out.
//   Chain side:   cnt_clr_l, cnt_ld_l, cnt_enp, cnt_ent and cnt_d go out to
//                 the counter stages; chain_rco comes back from the top stage.
//   modport slave  : the sequencer itself.
//   modport master : the surrounding system, which supplies the commands and
//                    the chain's RCO.
// ---------------------------------------------------------------------------
interface ctr163_chain_ctrl_if #(
    parameter int NSTAGE = 2
);
    localparam int W = 4 * NSTAGE;

    logic         start;
    logic         stop;
    logic         pause;
    logic         mode;
    logic [W-1:0] count;
    logic         chain_rco;

    logic         cnt_clr_l;
    logic         cnt_ld_l;
    logic         cnt_enp;
    logic         cnt_ent;
    logic [W-1:0] cnt_d;
    logic         busy;
    logic         tick;
    logic         done;

    modport slave (
        input  start, stop, pause, mode, count, chain_rco,
        output cnt_clr_l, cnt_ld_l, cnt_enp, cnt_ent, cnt_d, busy, tick, done
    );

    modport master (
        output start, stop, pause, mode, count, chain_rco,
        input  cnt_clr_l, cnt_ld_l, cnt_enp, cnt_ent, cnt_d, busy, tick, done
    );
endinterface

// File: rtl/ctr163_chain_ctrl.sv
// ---------------------------------------------------------------------------
// ctr163_chain_ctrl
//   Sequencer for a cascade of NSTAGE 74x163-style 4-bit synchronous counters
//   that together form a programmable timer.
//
//   A START request in IDLE captures the preset P = (2^W - count) mod 2^W.
//   The sequencer then clears the chain for one cycle and loads P for one
//   cycle. After that it enables counting until the top stage's RCO reports
//   terminal count. One-shot mode returns to IDLE and pulses DONE. Auto-reload
//   mode reloads P and counts again. PAUSE freezes counting by moving to HOLD,
//   where ENT stays high and ENP drops. STOP aborts from any state.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   bus (slave)    start/stop/pause/mode/count/chain_rco in;
//                  cnt_clr_l/cnt_ld_l/cnt_enp/cnt_ent/cnt_d/busy/tick/done out
// ---------------------------------------------------------------------------
module ctr163_chain_ctrl #(
    parameter int NSTAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    ctr163_chain_ctrl_if.slave   bus
);
    localparam int W = 4 * NSTAGE;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    logic [2:0]   state_reg,  state_next;
    logic [W-1:0] preset_reg, preset_next;
    logic         tick_reg,   tick_next;
    logic         done_reg,   done_next;
    logic [W-1:0] cnt_d_w;

    always_comb begin
        state_next  = state_reg;
        preset_next = preset_reg;
        tick_next   = 1'b0;
        done_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    // Counting up from 2^W - count reaches all-ones on the
                    // count-th enabled cycle. count = 0 wraps to P = 0,
                    // which gives a full 2^W run.
                    preset_next = {W{1'b0}} - bus.count;
                    state_next  = ST_CLR;
                end
            end
            ST_CLR: begin
                state_next = bus.stop ? ST_IDLE : ST_LOAD;
            end
            ST_LOAD: begin
                state_next = bus.stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_next = ST_IDLE;
                end else if (bus.chain_rco) begin
                    tick_next = 1'b1;
                    if (bus.mode) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end else if (bus.pause) begin
                    // The chain still advances on this edge, because ENP is
                    // high in RUN. Only the following cycles are frozen.
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // RCO can be high while the chain sits at terminal count with
                // ENT=1, so it is deliberately not acted on here.
                if (bus.stop) begin
                    state_next = ST_IDLE;
                end else if (!bus.pause) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            preset_reg <= '0;
            tick_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            preset_reg <= preset_next;
            tick_reg   <= tick_next;
            done_reg   <= done_next;
        end
    end

    // Each counter stage takes its own nibble of the preset on its D inputs.
    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage_d
            assign cnt_d_w[4*gi +: 4] = preset_reg[4*gi +: 4];
        end
    endgenerate

    // The chain controls are Moore decodes of the state register. An
    // asynchronous reset therefore forces them to their idle values at once.
    assign bus.cnt_clr_l = (state_reg != ST_CLR);
    assign bus.cnt_ld_l  = (state_reg != ST_LOAD);
    assign bus.cnt_enp   = (state_reg == ST_RUN);
    assign bus.cnt_ent   = (state_reg == ST_RUN) || (state_reg == ST_HOLD);
    assign bus.cnt_d     = cnt_d_w;
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.tick      = tick_reg;
    assign bus.done      = done_reg;
endmodule
